// File: rtl/mxint8_block_quantizer.sv
// Streaming FP32 -> MXINT8 block quantizer: ping-pong fills BLOCK_SIZE floats,
// derives a shared E8M0 scale, then emits one rounded INT8 element per cycle.
module mxint8_block_quantizer #(
  parameter int unsigned BLOCK_SIZE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] float32_i,
  input  logic        data_valid_i,
  output logic [7:0]  scale_o,
  output logic [7:0]  element_o,
  output logic        out_valid_o,
  output logic        block_last_o
);

  localparam int unsigned IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned EXT_W    = 56;
  localparam int unsigned SHIFT_W  = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  logic [31:0]      r_bank [2][BLOCK_SIZE];

  logic             r_fill_bank;
  logic [IDX_W-1:0] r_fill_idx;
  logic [7:0]       r_fill_max;
  logic             r_fill_nan;

  state_t           r_state;
  logic             r_emit_bank;
  logic [IDX_W-1:0] r_emit_idx;
  logic [7:0]       r_emit_scale;

  logic [7:0]       r_scale;
  logic [7:0]       r_element;
  logic             r_out_valid;
  logic             r_block_last;

  // Fill-side max/NaN fold, including the element arriving this cycle
  logic [7:0] w_in_exp;
  logic [7:0] w_fold_max;
  logic       w_fold_nan;
  logic       w_fill_done;
  logic [7:0] w_new_scale;

  assign w_in_exp    = float32_i[30:23];
  assign w_fold_max  = (w_in_exp > r_fill_max) ? w_in_exp : r_fill_max;
  assign w_fold_nan  = r_fill_nan | (w_in_exp == 8'hFF);
  assign w_fill_done = data_valid_i && (r_fill_idx == LAST_IDX);
  assign w_new_scale = w_fold_nan ? 8'hFF : w_fold_max;

  // Element datapath: align significand to the shared scale, round half-even
  logic [31:0]        w_elem_in;
  logic [7:0]         w_e;
  logic [7:0]         w_e_eff;
  logic [23:0]        w_sig;
  logic [SHIFT_W-1:0] w_shift_full;
  logic [4:0]         w_shift;
  logic [EXT_W-1:0]   w_ext;
  logic [23:0]        w_mag;
  logic               w_guard;
  logic               w_sticky;
  logic               w_round_up;
  logic [24:0]        w_rnd;
  logic [6:0]         w_clamp;
  logic [7:0]         w_element;

  assign w_elem_in    = r_bank[r_emit_bank][r_emit_idx];
  assign w_e          = w_elem_in[30:23];
  assign w_e_eff      = (w_e == 8'd0) ? 8'd1 : w_e;
  assign w_sig        = {(w_e != 8'd0), w_elem_in[22:0]};
  assign w_shift_full = SHIFT_W'(17) + SHIFT_W'(r_emit_scale) - SHIFT_W'(w_e_eff);
  assign w_shift      = (w_shift_full >= SHIFT_W'(31)) ? 5'd31 : w_shift_full[4:0];
  assign w_ext        = {w_sig, 32'd0} >> w_shift;
  assign w_mag        = w_ext[55:32];
  assign w_guard      = w_ext[31];
  assign w_sticky     = |w_ext[30:0];
  assign w_round_up   = w_guard & (w_sticky | w_mag[0]);
  assign w_rnd        = {1'b0, w_mag} + 25'(w_round_up);
  assign w_clamp      = (w_rnd > 25'd127) ? 7'd127 : w_rnd[6:0];

  always_comb begin
    w_element = {1'b0, w_clamp};
    if (r_emit_scale == 8'hFF) begin
      w_element = 8'h00;
    end else if (w_elem_in[31]) begin
      w_element = 8'h00 - {1'b0, w_clamp};
    end
  end

  // Bank storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (data_valid_i) begin
      r_bank[r_fill_bank][r_fill_idx] <= float32_i;
    end
  end

  // Fill pointer and per-bank max exponent / NaN tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_bank <= 1'b0;
      r_fill_idx  <= '0;
      r_fill_max  <= 8'h00;
      r_fill_nan  <= 1'b0;
    end else if (data_valid_i) begin
      if (w_fill_done) begin
        r_fill_idx  <= '0;
        r_fill_bank <= ~r_fill_bank;
        r_fill_max  <= 8'h00;
        r_fill_nan  <= 1'b0;
      end else begin
        r_fill_idx  <= r_fill_idx + IDX_W'(1);
        r_fill_max  <= w_fold_max;
        r_fill_nan  <= w_fold_nan;
      end
    end
  end

  // Emitter FSM with registered outputs; a hand-off on the final cycle chains blocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_emit_bank  <= 1'b0;
      r_emit_idx   <= '0;
      r_emit_scale <= 8'h00;
      r_scale      <= 8'h00;
      r_element    <= 8'h00;
      r_out_valid  <= 1'b0;
      r_block_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid  <= 1'b0;
          r_block_last <= 1'b0;
          if (w_fill_done) begin
            r_state      <= S_EMIT;
            r_emit_bank  <= r_fill_bank;
            r_emit_idx   <= '0;
            r_emit_scale <= w_new_scale;
          end
        end
        S_EMIT: begin
          r_out_valid  <= 1'b1;
          r_element    <= w_element;
          r_scale      <= r_emit_scale;
          r_block_last <= (r_emit_idx == LAST_IDX);
          if (r_emit_idx == LAST_IDX) begin
            r_emit_idx <= '0;
            if (w_fill_done) begin
              r_emit_bank  <= r_fill_bank;
              r_emit_scale <= w_new_scale;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_emit_idx <= r_emit_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scale_o      = r_scale;
  assign element_o    = r_element;
  assign out_valid_o  = r_out_valid;
  assign block_last_o = r_block_last;

endmodule

// File: tb/tb_mxint8_block_quantizer.sv
// Scoreboard bench for mxint8_block_quantizer at BLOCK_SIZE=4: directed blocks
// push expected elements (with expected cycle); a monitor pops and compares.
module tb_mxint8_block_quantizer;

  logic        clk;
  logic        rst_n;
  logic [31:0] float32_i;
  logic        data_valid_i;
  logic [7:0]  scale_o;
  logic [7:0]  element_o;
  logic        out_valid_o;
  logic        block_last_o;

  mxint8_block_quantizer #(.BLOCK_SIZE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .float32_i    (float32_i),
    .data_valid_i (data_valid_i),
    .scale_o      (scale_o),
    .element_o    (element_o),
    .out_valid_o  (out_valid_o),
    .block_last_o (block_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  sc;
    logic [7:0]  el;
    logic        last;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(out_valid_o), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("element", 32'(element_o), 32'(e.el));
        chk("scale", 32'(scale_o), 32'(e.sc));
        chk("block_last", 32'(block_last_o), 32'(e.last));
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive four consecutive elements and queue the expected block
  task automatic send_block(input logic [127:0] w, input logic [7:0] sc, input logic [31:0] el);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      float32_i    = w[127-32*k -: 32];
      data_valid_i = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      e.sc   = sc;
      e.el   = el[31-8*k -: 8];
      e.last = (k == 3);
      e.cyc  = cyc + 2 + k;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid_i = 1'b0;
      float32_i    = 32'h0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_scale"}, 32'(scale_o), 0);
    chk({tag, "_element"}, 32'(element_o), 0);
    chk({tag, "_valid"}, 32'(out_valid_o), 0);
    chk({tag, "_last"}, 32'(block_last_o), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    data_valid_i = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [127:0] PLAIN_W  = {32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h3E800000};
  localparam logic [31:0]  PLAIN_E  = {8'h40, 8'h20, 8'hC0, 8'h10};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    float32_i    = 32'h0;
    data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    send_block(PLAIN_W, 8'h7F, PLAIN_E);
    idle(6);
    // round half to even, max exponent 1.0
    send_block({32'h3CC00000, 32'h3D200000, 32'h3D600000, 32'h3F800000},
               8'h7F, {8'h02, 8'h02, 8'h04, 8'h40});
    idle(6);
    // rounding carry clamps to +/-127
    send_block({32'h3FFFFFFF, 32'hBFFFFFFF, 32'h3F800000, 32'h00000000},
               8'h7F, {8'h7F, 8'h81, 8'h40, 8'h00});
    idle(6);
    send_block({32'h3F800000, 32'h7FC00000, 32'h40000000, 32'hBF000000},
               8'hFF, 32'h0);
    idle(6);
    send_block({32'h3F800000, 32'h40000000, 32'hBF000000, 32'hFF800000},
               8'hFF, 32'h0);
    idle(6);
    send_block({32'h00400000, 32'h00400000, 32'h80200000, 32'h00000001},
               8'h00, {8'h40, 8'h40, 8'hE0, 8'h00});
    idle(6);

    // Back-to-back blocks with differing scales
    send_block({32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0800000},
               8'h81, {8'h10, 8'h20, 8'h08, 8'hC0});
    send_block({32'h3E000000, 32'h3E800000, 32'hBE000000, 32'h3D800000},
               8'h7D, {8'h20, 8'h40, 8'hE0, 8'h10});
    idle(8);

    // Reset after two elements of a third block
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      float32_i    = 32'h3F800000;
      data_valid_i = 1'b1;
    end
    @(negedge clk);
    data_valid_i = 1'b0;
    do_reset();
    check_zero("midfill_reset");
    rst_n = 1'b1;
    idle(3);
    send_block(PLAIN_W, 8'h7F, PLAIN_E);
    idle(8);

    // Reset while a block is being emitted
    send_block({32'h3F800000, 32'h40000000, 32'h3F000000, 32'hC0800000},
               8'h81, {8'h10, 8'h20, 8'h08, 8'hC0});
    idle(2);
    do_reset();
    check_zero("midemit_reset");
    rst_n = 1'b1;
    idle(4);
    send_block(PLAIN_W, 8'h7F, PLAIN_E);
    idle(10);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
